multicycle_control: RTL and testbench

Registered multi-cycle successor to the single-cycle opcode decoder of the KGP-RISC datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the same datapath control signals as the single-cycle decoder, but only in the cycles where they are needed. It adds instruction and data memory request/acknowledge handshakes, a parametrised multiply/divide wait, and a memory timeout fault.

---
 rtl/kgp_ctrl_pkg.sv | 29 ++
 rtl/multicycle_control_if.sv | 31 +++
 rtl/opcode_class_decoder.sv | 50 +++++
 rtl/multicycle_control.sv | 103 ++++++++++
 tb/tb_multicycle_control.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kgp_ctrl_pkg.sv
// Shared types and encodings for the KGP-RISC multi-cycle controller.
package kgp_ctrl_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, FAULT} state_e;

  typedef enum logic [2:0] {ALU, MUL, IMM, SHIFT, LOAD, STORE, LINK, BRANCH} cls_e;

  localparam logic [1:0] RW_NONE  = 2'd0;
  localparam logic [1:0] RW_RD    = 2'd1;
  localparam logic [1:0] RW_HILO  = 2'd2;
  localparam logic [1:0] RW_LINK  = 2'd3;

  localparam logic [1:0] AS_RT    = 2'd0;
  localparam logic [1:0] AS_SHAMT = 2'd1;
  localparam logic [1:0] AS_IMM   = 2'd2;
  localparam logic [1:0] AS_OFF   = 2'd3;

  typedef struct packed {
    cls_e       cls;
    logic [1:0] rw;
    logic [1:0] alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{cls: ALU, rw: RW_RD, alu_src: AS_RT,
                                 reg_dst: 1'b0, mem_to_reg: 1'b0};

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle; master is the controller side.
interface multicycle_control_if;
  logic       run;
  logic [5:0] opcode;
  logic       imem_ack;
  logic       dmem_ack;
  logic       imem_req;
  logic       ir_write;
  logic       pc_write;
  logic       dmem_req;
  logic [1:0] RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic [1:0] ALUSrc;
  logic       RegDst;
  logic       instr_done;
  logic       fault;

  modport master (
    input  run, opcode, imem_ack, dmem_ack,
    output imem_req, ir_write, pc_write, dmem_req, RegWrite, MemRead, MemWrite,
           MemtoReg, ALUSrc, RegDst, instr_done, fault
  );

  modport slave (
    output run, opcode, imem_ack, dmem_ack,
    input  imem_req, ir_write, pc_write, dmem_req, RegWrite, MemRead, MemWrite,
           MemtoReg, ALUSrc, RegDst, instr_done, fault
  );
endinterface

// File: rtl/opcode_class_decoder.sv
// Combinational opcode -> instruction class plus static datapath controls.
module opcode_class_decoder import kgp_ctrl_pkg::*; (
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_RST;
    case (opcode_i[5:4])
      2'b00: begin
        case (opcode_i[3:0])
          4'b0001, 4'b0010: begin
            ctrl_o.cls = MUL;
            ctrl_o.rw  = RW_HILO;
          end
          4'b0100, 4'b0101: begin
            ctrl_o.cls     = IMM;
            ctrl_o.alu_src = AS_IMM;
          end
          4'b1000, 4'b1001, 4'b1100: begin
            ctrl_o.cls     = SHIFT;
            ctrl_o.alu_src = AS_SHAMT;
          end
          default: ;
        endcase
      end
      2'b01: begin
        ctrl_o.cls        = LOAD;
        ctrl_o.alu_src    = AS_OFF;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      2'b10: begin
        ctrl_o.cls     = STORE;
        ctrl_o.alu_src = AS_OFF;
        ctrl_o.rw      = RW_NONE;
      end
      default: begin
        if (opcode_i[3:0] == 4'b1010) begin
          ctrl_o.cls = LINK;
          ctrl_o.rw  = RW_LINK;
        end else begin
          ctrl_o.cls = BRANCH;
          ctrl_o.rw  = RW_NONE;
        end
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes,
// a multiply/divide wait and a sticky memory-timeout fault.
module multicycle_control import kgp_ctrl_pkg::*; #(
  parameter int MUL_CYCLES  = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master bus
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam int MW = $clog2(MUL_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(MEM_TIMEOUT - 1);
  localparam logic [MW-1:0] MUL_LOAD = MW'(MUL_CYCLES - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] to_q, to_d;
  logic [MW-1:0] cnt_q, cnt_d;
  ctrl_t         ctrl_q, ctrl_d, dec_ctrl;
  logic          imem_req, fetch_ack, mem_ack;

  opcode_class_decoder u_dec (
    .opcode_i (bus.opcode),
    .ctrl_o   (dec_ctrl)
  );

  // A nonzero wait count means the fetch request is already raised, so it
  // stays up even if run drops before the ack.
  assign imem_req  = (state_q == FETCH) && (bus.run || (to_q != '0));
  assign fetch_ack = imem_req && bus.imem_ack;
  assign mem_ack   = (state_q == MEM) && bus.dmem_ack;

  always_comb begin
    state_d = state_q;
    to_d    = '0;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    case (state_q)
      FETCH: begin
        if (fetch_ack)               state_d = DECODE;
        else if (imem_req) begin
          if (to_q == TO_LAST)       state_d = FAULT;
          else                       to_d    = to_q + 1'b1;
        end
      end
      DECODE: begin
        ctrl_d  = dec_ctrl;
        cnt_d   = MUL_LOAD;
        state_d = EXEC;
      end
      EXEC: begin
        case (ctrl_q.cls)
          MUL: begin
            if (cnt_q == '0) state_d = WB;
            else             cnt_d   = cnt_q - 1'b1;
          end
          LOAD, STORE: state_d = MEM;
          BRANCH:      state_d = FETCH;
          default:     state_d = WB;
        endcase
      end
      MEM: begin
        if (mem_ack)                 state_d = (ctrl_q.cls == LOAD) ? WB : FETCH;
        else if (to_q == TO_LAST)    state_d = FAULT;
        else                         to_d    = to_q + 1'b1;
      end
      WB:      state_d = FETCH;
      FAULT:   state_d = FAULT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      to_q    <= '0;
      cnt_q   <= '0;
      ctrl_q  <= CTRL_RST;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.imem_req   = imem_req;
  assign bus.ir_write   = fetch_ack;
  assign bus.pc_write   = fetch_ack;
  assign bus.dmem_req   = (state_q == MEM);
  assign bus.MemRead    = (state_q == MEM) && (ctrl_q.cls == LOAD);
  assign bus.MemWrite   = (state_q == MEM) && (ctrl_q.cls == STORE);
  assign bus.RegWrite   = (state_q == WB) ? ctrl_q.rw : RW_NONE;
  assign bus.MemtoReg   = ctrl_q.mem_to_reg;
  assign bus.ALUSrc     = ctrl_q.alu_src;
  assign bus.RegDst     = ctrl_q.reg_dst;
  assign bus.instr_done = (state_q == WB)
                        || ((state_q == EXEC) && (ctrl_q.cls == BRANCH))
                        || (mem_ack && (ctrl_q.cls == STORE));
  assign bus.fault      = (state_q == FAULT);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected cycle traces built
// from the instruction-class rules, a constant latency table, and corner cases.
module tb_multicycle_control;

  localparam int MC = 4;
  localparam int TO = 16;

  localparam int C_ALU = 0, C_MUL = 1, C_IMM = 2, C_SHIFT = 3;
  localparam int C_LOAD = 4, C_STORE = 5, C_LINK = 6, C_BRANCH = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control #(.MUL_CYCLES(MC), .MEM_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       ia;
    logic       da;
    logic [5:0] op;
    logic [9:0] eo;
    logic       cs;
    logic [3:0] es;
  } cyc_t;

  typedef struct {
    logic [5:0] op;
    int         lat;
    logic [1:0] rw;
    logic [3:0] st;
  } vec_t;

  cyc_t       tr[$];
  vec_t       tbl[$];
  int         vectors = 0;
  int         miscompares = 0;
  bit         noise = 1'b0;
  logic [1:0] rw_seen;
  logic [3:0] st_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {bus.imem_req, bus.ir_write, bus.pc_write, bus.dmem_req, bus.RegWrite,
            bus.MemRead, bus.MemWrite, bus.instr_done, bus.fault};
  endfunction

  function automatic logic [3:0] stat();
    return {bus.ALUSrc, bus.RegDst, bus.MemtoReg};
  endfunction

  function automatic logic [9:0] mk(int req, int ack, int dreq, int rw, int mr, int mw,
                                    int done, int flt);
    return {1'(req), 1'(ack), 1'(ack), 1'(dreq), 2'(rw), 1'(mr), 1'(mw), 1'(done), 1'(flt)};
  endfunction

  function automatic int rb();
    return noise ? int'($urandom_range(0, 1)) : 0;
  endfunction

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  function automatic int cls_of(logic [5:0] op);
    logic [1:0] hi;
    logic [3:0] lo;
    hi = op[5:4];
    lo = op[3:0];
    if (hi == 2'b01) return C_LOAD;
    if (hi == 2'b10) return C_STORE;
    if (hi == 2'b11) return (lo == 4'd10) ? C_LINK : C_BRANCH;
    if (lo == 4'd1 || lo == 4'd2) return C_MUL;
    if (lo == 4'd4 || lo == 4'd5) return C_IMM;
    if (lo == 4'd8 || lo == 4'd9 || lo == 4'd12) return C_SHIFT;
    return C_ALU;
  endfunction

  function automatic int rw_of(int c);
    if (c == C_MUL) return 2;
    if (c == C_LINK) return 3;
    if (c == C_STORE || c == C_BRANCH) return 0;
    return 1;
  endfunction

  // {ALUSrc, RegDst, MemtoReg}
  function automatic logic [3:0] static_of(int c);
    if (c == C_IMM)   return 4'b1000;
    if (c == C_SHIFT) return 4'b0100;
    if (c == C_LOAD)  return 4'b1111;
    if (c == C_STORE) return 4'b1100;
    return 4'b0000;
  endfunction

  task automatic push(input int ia, input int da, input logic [5:0] op, input logic [9:0] eo,
                      input int cs, input logic [3:0] es);
    tr.push_back(cyc_t'{1'(ia), 1'(da), op, eo, 1'(cs), es});
  endtask

  // Expected trace of one instruction; a wait of TO or more means the ack never comes.
  task automatic build(input logic [5:0] op, input int wi, input int wd);
    int c, nexec;
    logic [3:0] st;
    bit ld, sto;
    tr.delete();
    c = cls_of(op);
    st = static_of(c);
    ld = (c == C_LOAD);
    sto = (c == C_STORE);
    if (wi >= TO) begin
      for (int i = 0; i < TO; i++) push(0, rb(), op, mk(1, 0, 0, 0, 0, 0, 0, 0), 0, 4'h0);
      for (int i = 0; i < 3; i++) push(rb(), rb(), junk(), mk(0, 0, 0, 0, 0, 0, 0, 1), 0, 4'h0);
      return;
    end
    for (int i = 0; i <= wi; i++)
      push(int'(i == wi), rb(), op, mk(1, int'(i == wi), 0, 0, 0, 0, 0, 0), 0, 4'h0);
    push(rb(), rb(), op, mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 4'h0);
    nexec = (c == C_MUL) ? MC : 1;
    for (int i = 0; i < nexec; i++)
      push(rb(), rb(), junk(), mk(0, 0, 0, 0, 0, 0, int'(c == C_BRANCH), 0), 1, st);
    if (ld || sto) begin
      if (wd >= TO) begin
        for (int j = 0; j < TO; j++)
          push(rb(), 0, junk(), mk(0, 0, 1, 0, int'(ld), int'(sto), 0, 0), 1, st);
        for (int j = 0; j < 3; j++)
          push(rb(), rb(), junk(), mk(0, 0, 0, 0, 0, 0, 0, 1), 1, st);
        return;
      end
      for (int j = 0; j <= wd; j++)
        push(rb(), int'(j == wd), junk(),
             mk(0, 0, 1, 0, int'(ld), int'(sto), int'(sto && j == wd), 0), 1, st);
    end
    if (c != C_BRANCH && !sto)
      push(rb(), rb(), junk(), mk(0, 0, 0, rw_of(c), 0, 0, 1, 0), 1, st);
  endtask

  task automatic apply(input int maxc, output int lat);
    logic [9:0] act;
    logic [3:0] ast;
    lat = -1;
    rw_seen = 2'b00;
    st_done = 4'h0;
    for (int i = 0; i < tr.size() && i < maxc; i++) begin
      bus.imem_ack = tr[i].ia;
      bus.dmem_ack = tr[i].da;
      bus.opcode = tr[i].op;
      @(negedge clk);
      act = outs();
      ast = stat();
      chk($sformatf("out c%0d", i), 32'(act), 32'(tr[i].eo));
      if (tr[i].cs) chk($sformatf("static c%0d", i), 32'(ast), 32'(tr[i].es));
      rw_seen = rw_seen | bus.RegWrite;
      if (lat < 0 && bus.instr_done) begin
        lat = i;
        st_done = ast;
      end
      @(posedge clk);
      #1;
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  task automatic idle_chk(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(nm, 32'(outs()), 32'd0);
      chk({nm, " static"}, 32'(stat()), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.run = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_chk("post-rst", 2);
    bus.run = 1'b1;
  endtask

  initial begin
    int lat, wi, wd;
    rst = 1'b1;
    bus.run = 1'b0;
    bus.opcode = 6'd0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;

    tbl.push_back(vec_t'{6'b000000, 4, 2'd1, 4'b0000});
    tbl.push_back(vec_t'{6'b000011, 4, 2'd1, 4'b0000});
    tbl.push_back(vec_t'{6'b000001, 3 + MC, 2'd2, 4'b0000});
    tbl.push_back(vec_t'{6'b000010, 3 + MC, 2'd2, 4'b0000});
    tbl.push_back(vec_t'{6'b000100, 4, 2'd1, 4'b1000});
    tbl.push_back(vec_t'{6'b000101, 4, 2'd1, 4'b1000});
    tbl.push_back(vec_t'{6'b001000, 4, 2'd1, 4'b0100});
    tbl.push_back(vec_t'{6'b001001, 4, 2'd1, 4'b0100});
    tbl.push_back(vec_t'{6'b001100, 4, 2'd1, 4'b0100});
    tbl.push_back(vec_t'{6'b001111, 4, 2'd1, 4'b0000});
    tbl.push_back(vec_t'{6'b010000, 5, 2'd1, 4'b1111});
    tbl.push_back(vec_t'{6'b011111, 5, 2'd1, 4'b1111});
    tbl.push_back(vec_t'{6'b100000, 4, 2'd0, 4'b1100});
    tbl.push_back(vec_t'{6'b101010, 4, 2'd0, 4'b1100});
    tbl.push_back(vec_t'{6'b111010, 4, 2'd3, 4'b0000});
    tbl.push_back(vec_t'{6'b110000, 3, 2'd0, 4'b0000});
    tbl.push_back(vec_t'{6'b111011, 3, 2'd0, 4'b0000});

    repeat (2) @(posedge clk);
    #1;
    idle_chk("reset", 1);
    rst = 1'b0;
    idle_chk("run0 idle", 3);
    bus.run = 1'b1;

    foreach (tbl[k]) begin
      build(tbl[k].op, 0, 0);
      apply(1000, lat);
      chk($sformatf("latency op%b", tbl[k].op), 32'(lat + 1), 32'(tbl[k].lat));
      chk($sformatf("regwrite op%b", tbl[k].op), 32'(rw_seen), 32'(tbl[k].rw));
      chk($sformatf("static op%b", tbl[k].op), 32'(st_done), 32'(tbl[k].st));
    end

    // Load with a 3-cycle dmem wait, store with a 5-cycle wait.
    build(6'b010000, 0, 3);
    apply(1000, lat);
    chk("load wait3 latency", 32'(lat + 1), 32'd8);
    build(6'b100000, 2, 5);
    apply(1000, lat);
    chk("store wait5 regwrite", 32'(rw_seen), 32'd0);

    // Ack on the last permitted wait cycle wins over the timeout.
    build(6'b010000, 0, TO - 1);
    apply(1000, lat);
    build(6'b000000, TO - 1, 0);
    apply(1000, lat);

    // Reset in the middle of a multiply, then run=0 keeps FETCH idle.
    build(6'b000001, 0, 0);
    apply(4, lat);
    rst = 1'b1;
    @(negedge clk);
    chk("mul exec under rst", 32'(outs()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.run = 1'b0;
    idle_chk("after mul rst", 3);
    bus.run = 1'b1;

    // Data and instruction memory timeouts into FAULT, cleared only by rst.
    build(6'b010000, 0, TO);
    apply(1000, lat);
    do_reset();
    build(6'b000000, TO, 0);
    apply(1000, lat);
    do_reset();

    noise = 1'b1;
    for (int n = 0; n < 300; n++) begin
      wi = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
      wd = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
      build(6'($urandom), wi, wd);
      apply(1000, lat);
    end
    noise = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
